// File: rtl/uart_recv_block.sv
// uart_recv_block
// Receives 8N1 serial bytes on RxD and packs N consecutive bytes into one
// W*N-bit pixel block. The block is handed on with a finish/finish_ack
// handshake.
//
// States
//   S_IDLE      | line idle, waiting for a low level on rxs
//   S_START     | timing to the middle of the start bit to confirm it
//   S_DATA      | sampling W data bits, LSB first, one per bit period
//   S_STOP      | sampling the stop bit; a high level accepts the byte
//   S_WAIT_HIGH | after a framing error, waiting for the line to go high
//
// Ports
//   clk        in   single clock
//   rst        in   synchronous, active-high reset
//   RxD        in   asynchronous serial line, idles high
//   rx_byte    out  most recently received byte
//   rx_valid   out  one-cycle pulse when rx_byte updates
//   data_out   out  assembled block, byte 0 in the top W bits
//   finish     out  block complete, held until acknowledged
//   finish_ack in   consumer accepted the block
//   frame_err  out  one-cycle pulse on a bad stop bit
//   overrun    out  one-cycle pulse when a byte is dropped while finish is high
module uart_recv_block #(
    parameter int CLKS_PER_BIT = 868,
    parameter int N            = 16,
    parameter int W            = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RxD,
    output logic [W-1:0]   rx_byte,
    output logic           rx_valid,
    output logic [W*N-1:0] data_out,
    output logic           finish,
    input  logic           finish_ack,
    output logic           frame_err,
    output logic           overrun
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rxs_q, rxs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [W-1:0]     rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic [W*N-1:0]   data_q, data_d;
    logic             finish_q, finish_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             byte_done;

    always_comb begin
        rx_meta_d   = RxD;
        rxs_d       = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        wr_idx_d    = wr_idx_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        data_d      = data_q;
        finish_d    = finish_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;

        if (finish_q && finish_ack) begin
            finish_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    if (bit_idx_q == BIT_W'(W - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (byte_done) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            // A completed block stays frozen until acknowledged, even if the
            // ack arrives in this same cycle.
            if (finish_q) begin
                overrun_d = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (wr_idx_q == IDX_W'(i)) begin
                        data_d[(N-1-i)*W +: W] = shift_q;
                    end
                end
                if (wr_idx_q == IDX_W'(N - 1)) begin
                    wr_idx_d = '0;
                    finish_d = 1'b1;
                end else begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_idx_q    <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            data_q      <= '0;
            finish_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_idx_q    <= wr_idx_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            data_q      <= data_d;
            finish_q    <= finish_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign data_out  = data_q;
    assign finish    = finish_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_recv_block.sv
// Directed bench for uart_recv_block at CLKS_PER_BIT=16.
module tb_uart_recv_block;

    localparam int CPB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         RxD;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [127:0] data_out;
    logic         finish;
    logic         finish_ack;
    logic         frame_err;
    logic         overrun;

    uart_recv_block #(.CLKS_PER_BIT(CPB), .N(16), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .RxD        (RxD),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .data_out   (data_out),
        .finish     (finish),
        .finish_ack (finish_ack),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_valid = 0;
    int   n_ferr  = 0;
    int   n_ovr   = 0;
    int   valid_cyc = 0;
    logic fin_at_valid = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            valid_cyc    = cyc;
            fin_at_valid = finish;
        end
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
    end

    int n_vec  = 0;
    int n_miss = 0;
    int start_cyc = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a rising edge; frames chain with no gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int stop_len);
        RxD = 1'b0;
        start_cyc = cyc;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            idle(CPB);
        end
        RxD = stop_lvl;
        idle(stop_len);
        RxD = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        RxD = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic ack_block(input string tag);
        finish_ack = 1'b1;
        chk({tag, "_fin_before"}, 128'(finish), 128'd1);
        idle(1);
        finish_ack = 1'b0;
        chk({tag, "_fin_after"}, 128'(finish), 128'd0);
    endtask

    int v0, f0, o0;
    logic [127:0] blk;

    initial begin
        rst = 1'b1;
        RxD = 1'b1;
        finish_ack = 1'b0;
        do_reset();

        chk("rst_rx_byte",   128'(rx_byte),   128'd0);
        chk("rst_rx_valid",  128'(rx_valid),  128'd0);
        chk("rst_data_out",  data_out,        128'd0);
        chk("rst_finish",    128'(finish),    128'd0);
        chk("rst_frame_err", 128'(frame_err), 128'd0);
        chk("rst_overrun",   128'(overrun),   128'd0);

        // single byte
        send_byte(8'hA5, 1'b1, CPB);
        chk("single_latency", 128'(valid_cyc - start_cyc), 128'd155);
        chk("single_rx_byte", 128'(rx_byte), 128'hA5);
        chk("single_slot0",   128'(data_out[127:120]), 128'hA5);
        chk("single_finish",  128'(finish), 128'd0);
        chk("single_nvalid",  128'(n_valid), 128'd1);

        // full block, back-to-back
        do_reset();
        v0 = n_valid;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, CPB);
        chk("block_nvalid",   128'(n_valid - v0), 128'd16);
        chk("block_fin_edge", 128'(fin_at_valid), 128'd1);
        chk("block_finish",   128'(finish), 128'd1);
        chk("block_data",     data_out, 128'h000102030405060708090A0B0C0D0E0F);

        // overrun while finish is held
        o0 = n_ovr;
        send_byte(8'h55, 1'b1, CPB);
        chk("ovr_rx_byte", 128'(rx_byte), 128'h55);
        chk("ovr_pulse",   128'(n_ovr - o0), 128'd1);
        chk("ovr_data",    data_out, 128'h000102030405060708090A0B0C0D0E0F);
        chk("ovr_finish",  128'(finish), 128'd1);
        ack_block("ack1");

        o0 = n_ovr;
        for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1, CPB);
        chk("ff_data",   data_out, {128{1'b1}});
        chk("ff_finish", 128'(finish), 128'd1);
        chk("ff_no_ovr", 128'(n_ovr - o0), 128'd0);
        ack_block("ack2");

        // frame error: one good byte in slot 0, bad byte, then 0x12 to slot 1
        send_byte(8'h77, 1'b1, CPB);
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'h3C, 1'b0, 20);
        idle(20);
        chk("ferr_pulse",   128'(n_ferr - f0), 128'd1);
        chk("ferr_novalid", 128'(n_valid - v0), 128'd0);
        send_byte(8'h12, 1'b1, CPB);
        blk = {8'h77, 8'h12, {14{8'hFF}}};
        chk("ferr_next_data", data_out, blk);
        chk("ferr_next_byte", 128'(rx_byte), 128'h12);

        // glitch
        v0 = n_valid;
        f0 = n_ferr;
        RxD = 1'b0;
        idle(3);
        RxD = 1'b1;
        idle(40);
        chk("glitch_novalid", 128'(n_valid - v0), 128'd0);
        chk("glitch_noferr",  128'(n_ferr - f0), 128'd0);
        send_byte(8'h81, 1'b1, CPB);
        chk("glitch_next_byte", 128'(rx_byte), 128'h81);
        blk = {8'h77, 8'h12, 8'h81, {13{8'hFF}}};
        chk("glitch_next_data", data_out, blk);

        // reset in the middle of a byte after five stored bytes
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i), 1'b1, CPB);
        chk("mid_pre_data", data_out[127:88], 40'hB0B1B2B3B4);
        v0 = n_valid;
        RxD = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            RxD = 1'b1;
            idle(CPB);
        end
        RxD = 1'b0;
        idle(8);
        rst = 1'b1;
        RxD = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("mid_rx_byte",   128'(rx_byte),   128'd0);
        chk("mid_data_out",  data_out,        128'd0);
        chk("mid_finish",    128'(finish),    128'd0);
        chk("mid_flags",     128'({rx_valid, frame_err, overrun}), 128'd0);
        idle(CPB * 12);
        chk("mid_no_valid",  128'(n_valid - v0), 128'd0);
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1, CPB);
        chk("mid_block_data", data_out, 128'h202122232425262728292A2B2C2D2E2F);
        chk("mid_block_fin",  128'(finish), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_recv_block.md
# uart_recv_block

Serial receive front end for the image-compression board link: the receiving end of the UART transmit path. Deserialises 8N1 bytes from the RxD pin and packs 16 consecutive bytes into one 128-bit 4×4 pixel block. The block is presented with the same `finish`/`finish_ack` handshake the pipeline stages already use, so it can feed `dpcm`-style consumers or a loop-back checker directly.

## Interface

Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal minimum is 4.
- `N`, 16: bytes per block.
- `W`, 8: bits per byte.

Ports:
- `clk` input, 1: single clock for all logic.
- `rst` input, 1: synchronous, active-high reset.
- `RxD` input, 1: asynchronous serial line; idles high.
- `rx_byte` output, W: most recently received byte.
- `rx_valid` output, 1: one-cycle pulse when `rx_byte` updates.
- `data_out` output, W*N: assembled block. Byte 0 (first received) is in `[W*N-1 -: W]`; byte 15 is in `[W-1:0]`.
- `finish` output, 1: block complete; held high until acknowledged.
- `finish_ack` input, 1: consumer accepted the block.
- `frame_err` output, 1: one-cycle pulse when a stop bit is bad.
- `overrun` output, 1: one-cycle pulse when a byte is dropped because `finish` is high.

## Operation

- **Synchroniser:** `RxD` passes through a 2-FF synchroniser, reset value 1. The FSM uses only the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** go to START on `rxs==0`, clear the bit counter `cnt`.
  - **START:** at `cnt==HALF-1` (HALF = CLKS_PER_BIT/2, integer), sample `rxs`.
    - If 0: go to DATA, set `cnt=0`, set bit index 0.
    - If 1: treat as a glitch and return to IDLE with no outputs.
  - **DATA:** at each `cnt==CLKS_PER_BIT-1`, sample `rxs` into shift bit [index], LSB first, and reset `cnt`. After bit 7 is sampled, go to STOP.
  - **STOP:** at `cnt==CLKS_PER_BIT-1`, sample `rxs`.
    - If 1: byte is good; go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rxs==1`, then go to IDLE.
- **Good byte, next cycle:**
  - `rx_byte` takes the byte and `rx_valid` pulses.
  - If `finish==0`: the byte is written into slot `wr_idx`, and `wr_idx` (0..N-1) increments.
  - If slot N-1 was written: `finish` is set and `wr_idx` wraps to 0.
  - If `finish==1`: the byte is not stored, `overrun` pulses, and `data_out` is unchanged. `rx_byte` and `rx_valid` still update.
- **Handshake:** `finish` clears on the cycle after `finish_ack` is sampled high while `finish==1`. `finish_ack` while `finish==0` is ignored.
- **`data_out` stability:** `data_out` is stable while `finish==1`. Slots are overwritten only by the next block's bytes.
- **Simultaneous ack and byte completion:** if a good byte completes in the same cycle that `finish_ack` is sampled, the byte is dropped (`overrun`). `finish` is still high that cycle.
- **Reset values:**
  - State IDLE, `cnt=0`, `wr_idx=0`, synchroniser = 1.
  - `rx_byte=0`, `rx_valid=0`, `data_out=0`, `finish=0`, `frame_err=0`, `overrun=0`.
- **Reset mid-operation:** a reset in the middle of a byte or a block discards the partial byte and the partial block. There is no recovery of partial data.

## Timing

- Let T0 be the first cycle with `rxs==0` in IDLE. T0 is 2 cycles after the pin falls.
- Start-bit sample at T0+HALF.
- Data bit k (k = 0..7) sampled at T0 + HALF + (k+1)·CLKS_PER_BIT.
- Stop-bit sample at T0 + HALF + 9·CLKS_PER_BIT.
- `rx_valid`, `frame_err`, `overrun` and the slot write are registered and visible at T0 + HALF + 9·CLKS_PER_BIT + 1.
- `finish` rises in the same cycle as the 16th stored `rx_valid`.
- Back-to-back frames with no idle gap are supported. The FSM is back in IDLE before the next start edge arrives.
- Throughput: one byte per 10·CLKS_PER_BIT cycles.

## Test plan

All scenarios use `CLKS_PER_BIT=16`.

- **Single byte:** send 0xA5 with a good stop bit. `rx_valid` pulses at T0+153 with `rx_byte=0xA5`, `data_out[127:120]=0xA5`, `finish=0`.
- **Full block:** send bytes 0x00..0x0F back-to-back. `finish=1` with `data_out=0x000102030405060708090A0B0C0D0E0F`. Pulse `finish_ack` once; `finish` falls on the next cycle.
- **Overrun:** with `finish=1` and no ack, send 0x55. `rx_byte=0x55`, `overrun` pulses, `data_out` is unchanged. After the ack, send 16 bytes of 0xFF; `data_out` is all 1s.
- **Frame error:** send 0x3C with stop bit 0, holding the line low for 20 cycles. `frame_err` pulses once, `rx_valid` stays 0, and `wr_idx` is unchanged. The next good byte 0x12 lands in the expected slot.
- **Glitch:** drive `RxD` low for 3 cycles only. No `rx_valid` and no `frame_err`; the FSM is back in IDLE. A following 0x81 is received correctly.
- **Reset mid-byte:** assert `rst` during bit 4 of a byte, after 5 bytes of a block have been stored. All outputs return to their reset values. The next 16 bytes form a complete block starting at slot 0.
